// File: rtl/otter_mmio_pkg.sv
// Shared address-map constants for the OTTER MMIO hub.
// Region offsets are relative to the hub's BASE_AD parameter.
package otter_mmio_pkg;

    // Region offsets
    localparam logic [31:0] IN_OFS  = 32'h0000_0000;
    localparam logic [31:0] OUT_OFS = 32'h0008_0000;
    localparam logic [31:0] IRQ_OFS = 32'h0010_0000;
    localparam logic [31:0] TMR_OFS = 32'h0014_0000;

    // Register offsets within the IRQ and timer regions
    localparam logic [31:0] PEND_REG = 32'h0000_0000;
    localparam logic [31:0] MASK_REG = 32'h0000_0004;
    localparam logic [31:0] TCNT_REG = 32'h0000_0000;
    localparam logic [31:0] TCMP_REG = 32'h0000_0004;

    localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

    // Word address of entry idx inside a region
    function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                             input logic [31:0] ofs,
                                             input logic [31:0] idx);
        return base + ofs + (idx << 2);
    endfunction

endpackage

// File: rtl/otter_sync2.sv
// Parametrised-width two-flop synchronizer with synchronous active-high reset.
module otter_sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] s1_q;
    logic [Width-1:0] s2_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/otter_mmio_hub.sv
// OTTER MMIO hub: synchronized input ports, output registers, edge-triggered
// interrupt pending/mask logic and an optional free-running timer.
// Define OTTER_MMIO_TIMER_EN to build in the TCNT/TCMP timer, which adds
// pending bit N_IRQ.
module otter_mmio_hub
    import otter_mmio_pkg::*;
#(
    parameter int unsigned N_IN    = 1,
    parameter int unsigned N_OUT   = 2,
    parameter int unsigned N_IRQ   = 1,
    parameter logic [31:0] BASE_AD = 32'h1100_0000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           IOBUS_ADDR,
    input  logic [31:0]           IOBUS_OUT,
    input  logic                  IOBUS_WR,
    output logic [31:0]           IOBUS_IN,
    input  logic [32*N_IN-1:0]    IN_PORTS,
    output logic [32*N_OUT-1:0]   OUT_PORTS,
    input  logic [N_IRQ-1:0]      IRQ_SRC,
    output logic                  INTR
);

`ifdef OTTER_MMIO_TIMER_EN
    localparam int unsigned PendW = N_IRQ + 1;
`else
    localparam int unsigned PendW = N_IRQ;
`endif

    localparam logic [31:0] PendAddr = BASE_AD + IRQ_OFS + PEND_REG;
    localparam logic [31:0] MaskAddr = BASE_AD + IRQ_OFS + MASK_REG;

    logic hit_pend;
    logic hit_mask;
    logic wr_pend;
    logic wr_mask;

    assign hit_pend = (IOBUS_ADDR == PendAddr);
    assign hit_mask = (IOBUS_ADDR == MaskAddr);
    assign wr_pend  = IOBUS_WR && hit_pend;
    assign wr_mask  = IOBUS_WR && hit_mask;

    // ---------------- Input ports ----------------
    logic [32*N_IN-1:0] in_sync;

    otter_sync2 #(
        .Width(32 * N_IN)
    ) u_in_sync (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  (IN_PORTS),
        .q_o  (in_sync)
    );

    // ---------------- Interrupt edge detect ----------------
    logic [N_IRQ-1:0] irq_sync;
    logic [N_IRQ-1:0] irq_dly_q;
    logic [N_IRQ-1:0] irq_edge;

    otter_sync2 #(
        .Width(N_IRQ)
    ) u_irq_sync (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  (IRQ_SRC),
        .q_o  (irq_sync)
    );

    // Delay flop holds the previous synchronized level for rise detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_dly_q <= '0;
        end else begin
            irq_dly_q <= irq_sync;
        end
    end

    assign irq_edge = irq_sync & ~irq_dly_q;

    // ---------------- Output registers ----------------
    logic [31:0] out_q [N_OUT];
    logic [31:0] out_d [N_OUT];

    // Exact-address write decode for each output register
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            out_d[j] = out_q[j];
            if (IOBUS_WR && (IOBUS_ADDR == reg_addr(BASE_AD, OUT_OFS, 32'(j)))) begin
                out_d[j] = IOBUS_OUT;
            end
        end
    end

    // Output register state
    always_ff @(posedge CLK) begin
        for (int j = 0; j < N_OUT; j++) begin
            if (RST) begin
                out_q[j] <= '0;
            end else begin
                out_q[j] <= out_d[j];
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign OUT_PORTS[32*j +: 32] = out_q[j];
    end

    // ---------------- Timer ----------------
    logic [PendW-1:0] pend_set;

`ifdef OTTER_MMIO_TIMER_EN
    localparam logic [31:0] TcntAddr = BASE_AD + TMR_OFS + TCNT_REG;
    localparam logic [31:0] TcmpAddr = BASE_AD + TMR_OFS + TCMP_REG;

    logic        hit_tcnt;
    logic        hit_tcmp;
    logic [31:0] tcnt_q;
    logic [31:0] tcnt_d;
    logic [31:0] tcmp_q;
    logic [31:0] tcmp_d;
    logic        tmr_hit;

    assign hit_tcnt = (IOBUS_ADDR == TcntAddr);
    assign hit_tcmp = (IOBUS_ADDR == TcmpAddr);

    // Count every cycle; a bus write to TCNT takes priority over the increment
    always_comb begin
        tcnt_d = tcnt_q + 32'd1;
        tcmp_d = tcmp_q;
        if (IOBUS_WR && hit_tcnt) begin
            tcnt_d = IOBUS_OUT;
        end
        if (IOBUS_WR && hit_tcmp) begin
            tcmp_d = IOBUS_OUT;
        end
    end

    // Timer state
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt_q <= '0;
            tcmp_q <= TCMP_RST;
        end else begin
            tcnt_q <= tcnt_d;
            tcmp_q <= tcmp_d;
        end
    end

    assign tmr_hit  = (tcnt_q == tcmp_q);
    assign pend_set = {tmr_hit, irq_edge};
`else
    assign pend_set = irq_edge;
`endif

    // ---------------- Pending / mask / interrupt ----------------
    logic [PendW-1:0] pend_q;
    logic [PendW-1:0] pend_d;
    logic [PendW-1:0] pend_clr;
    logic [PendW-1:0] mask_q;
    logic [PendW-1:0] mask_d;
    logic             intr_q;
    logic             intr_d;

    // W1C clear applied before OR-ing in new events, so a same-cycle set wins
    always_comb begin
        pend_clr = wr_pend ? IOBUS_OUT[PendW-1:0] : '0;
        pend_d   = (pend_q & ~pend_clr) | pend_set;
        mask_d   = wr_mask ? IOBUS_OUT[PendW-1:0] : mask_q;
        intr_d   = |(pend_q & mask_q);
    end

    // Pending, mask and interrupt state
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q <= '0;
            mask_q <= '0;
            intr_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            intr_q <= intr_d;
        end
    end

    assign INTR = intr_q;

    // ---------------- Read mux ----------------
    // Zero-latency read: unmapped addresses return zero
    always_comb begin
        IOBUS_IN = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (IOBUS_ADDR == reg_addr(BASE_AD, IN_OFS, 32'(i))) begin
                IOBUS_IN = in_sync[32*i +: 32];
            end
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (IOBUS_ADDR == reg_addr(BASE_AD, OUT_OFS, 32'(j))) begin
                IOBUS_IN = out_q[j];
            end
        end
        if (hit_pend) begin
            IOBUS_IN = 32'(pend_q);
        end
        if (hit_mask) begin
            IOBUS_IN = 32'(mask_q);
        end
`ifdef OTTER_MMIO_TIMER_EN
        if (hit_tcnt) begin
            IOBUS_IN = tcnt_q;
        end
        if (hit_tcmp) begin
            IOBUS_IN = tcmp_q;
        end
`endif
    end

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Self-checking bench for otter_mmio_hub: directed scenarios followed by
// randomized bus/pin traffic, all checked against a cycle-level reference
// model built from the address map and pin-to-register latencies.
module tb_otter_mmio_hub;

    localparam int unsigned N_IN  = 2;
    localparam int unsigned N_OUT = 2;
    localparam int unsigned N_IRQ = 3;
    localparam logic [31:0] BASE  = 32'h1100_0000;

`ifdef OTTER_MMIO_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    localparam int unsigned PW = N_IRQ + (TMR ? 1 : 0);

    localparam logic [31:0] A_OUT0 = BASE + 32'h0008_0000;
    localparam logic [31:0] A_OUT1 = BASE + 32'h0008_0004;
    localparam logic [31:0] A_PEND = BASE + 32'h0010_0000;
    localparam logic [31:0] A_MASK = BASE + 32'h0010_0004;
    localparam logic [31:0] A_TCNT = BASE + 32'h0014_0000;
    localparam logic [31:0] A_TCMP = BASE + 32'h0014_0004;

    logic                CLK = 1'b0;
    logic                RST;
    logic [31:0]         IOBUS_ADDR;
    logic [31:0]         IOBUS_OUT;
    logic                IOBUS_WR;
    logic [31:0]         IOBUS_IN;
    logic [32*N_IN-1:0]  IN_PORTS;
    logic [32*N_OUT-1:0] OUT_PORTS;
    logic [N_IRQ-1:0]    IRQ_SRC;
    logic                INTR;

    otter_mmio_hub #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .N_IRQ  (N_IRQ),
        .BASE_AD(BASE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .IOBUS_IN  (IOBUS_IN),
        .IN_PORTS  (IN_PORTS),
        .OUT_PORTS (OUT_PORTS),
        .IRQ_SRC   (IRQ_SRC),
        .INTR      (INTR)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    logic [31:0]        m_out [N_OUT];
    logic [31:0]        m_pend = '0;
    logic [31:0]        m_mask = '0;
    logic [31:0]        m_tcnt = '0;
    logic [31:0]        m_tcmp = 32'hFFFF_FFFF;
    logic               m_intr = 1'b0;
    // Pin levels seen at the last three edges (0 = most recent)
    logic [N_IRQ-1:0]   ih0 = '0, ih1 = '0, ih2 = '0;
    logic [32*N_IN-1:0] inh0 = '0, inh1 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pmask();
        return (32'd1 << PW) - 32'd1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        if (d[1:0] != 2'b00) return 32'h0;
        if (d < 4 * N_IN) return inh1[32*int'(d >> 2) +: 32];
        if (d >= 32'h0008_0000 && d < 32'h0008_0000 + 4 * N_OUT)
            return m_out[int'((d - 32'h0008_0000) >> 2)];
        if (d == 32'h0010_0000) return m_pend;
        if (d == 32'h0010_0004) return m_mask;
        if (TMR && d == 32'h0014_0000) return m_tcnt;
        if (TMR && d == 32'h0014_0004) return m_tcmp;
        return 32'h0;
    endfunction

    // Advance the model across one rising edge using the currently driven inputs
    task automatic model_edge();
        logic [31:0] d, set, clr;
        logic        intr_n;
        if (RST) begin
            for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
            m_pend = '0; m_mask = '0; m_intr = 1'b0;
            m_tcnt = '0; m_tcmp = 32'hFFFF_FFFF;
            ih0 = '0; ih1 = '0; ih2 = '0;
            inh0 = '0; inh1 = '0;
        end else begin
            d = IOBUS_ADDR - BASE;
            // A pin rise seen two edges ago becomes pending now
            set = 32'(ih1 & ~ih2);
            if (TMR && m_tcnt == m_tcmp) set = set | (32'd1 << N_IRQ);
            intr_n = |(m_pend & m_mask);
            clr = (IOBUS_WR && d == 32'h0010_0000) ? (IOBUS_OUT & pmask()) : 32'h0;
            m_pend = (m_pend & ~clr) | set;
            if (IOBUS_WR && d == 32'h0010_0004) m_mask = IOBUS_OUT & pmask();
            for (int j = 0; j < N_OUT; j++)
                if (IOBUS_WR && d == 32'h0008_0000 + 32'(4 * j)) m_out[j] = IOBUS_OUT;
            if (TMR) begin
                if (IOBUS_WR && d == 32'h0014_0000) m_tcnt = IOBUS_OUT;
                else m_tcnt = m_tcnt + 32'd1;
                if (IOBUS_WR && d == 32'h0014_0004) m_tcmp = IOBUS_OUT;
            end
            m_intr = intr_n;
            ih2 = ih1; ih1 = ih0; ih0 = IRQ_SRC;
            inh1 = inh0; inh0 = IN_PORTS;
        end
    endtask

    // One clock: edge, model update, then compare everything observable
    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check("rd", 64'(IOBUS_IN), 64'(model_read(IOBUS_ADDR)));
        check("out_ports", 64'(OUT_PORTS), {m_out[1], m_out[0]});
        check("intr", 64'(INTR), 64'(m_intr));
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        step();
        IOBUS_WR   = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        IOBUS_ADDR = a;
        IOBUS_WR   = 1'b0;
        step();
    endtask

    function automatic logic [31:0] pick_addr(input int unsigned sel);
        case (sel)
            0:       return BASE;
            1:       return BASE + 32'h4;
            2:       return BASE + 32'h8;
            3:       return A_OUT0;
            4:       return A_OUT1;
            5:       return A_OUT0 + 32'h8;
            6:       return A_PEND;
            7:       return A_MASK;
            8:       return A_TCNT;
            9:       return A_TCMP;
            10:      return A_PEND + 32'h8;
            11:      return BASE + 32'h2;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
        RST        = 1'b1;
        IOBUS_ADDR = A_MASK;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        IN_PORTS   = '0;
        IRQ_SRC    = '0;
        @(negedge CLK);

        // Reset state
        step();
        check("rst_mask", 64'(IOBUS_IN), 64'h0);
        IOBUS_ADDR = A_TCMP;
        step();
`ifdef OTTER_MMIO_TIMER_EN
        check("rst_tcmp", 64'(IOBUS_IN), 64'hFFFF_FFFF);
`else
        check("rst_tcmp_unmapped", 64'(IOBUS_IN), 64'h0);
`endif
        check("rst_out", 64'(OUT_PORTS), 64'h0);
        check("rst_intr", 64'(INTR), 64'h0);
        RST = 1'b0;

        // Output register write and readback
        bus_wr(A_OUT1, 32'h0000_BEEF);
        check("out1_port", 64'(OUT_PORTS[63:32]), 64'h0000_BEEF);
        check("out0_port", 64'(OUT_PORTS[31:0]), 64'h0);
        bus_rd(A_OUT1);
        check("out1_rd", 64'(IOBUS_IN), 64'h0000_BEEF);

        // Input synchronizer latency
        IN_PORTS[15:0] = 16'hA5A5;
        bus_rd(BASE);
        check("in_edge_k", 64'(IOBUS_IN), 64'h0);
        bus_rd(BASE);
        check("in_edge_k1", 64'(IOBUS_IN), 64'h0000_A5A5);

        // Interrupt set, INTR, W1C and no re-trigger while held high
        bus_wr(A_MASK, 32'h1);
        IRQ_SRC = 3'b001;
        bus_rd(A_PEND);
        bus_rd(A_PEND);
        check("pend_k1", 64'(IOBUS_IN), 64'h0);
        bus_rd(A_PEND);
        check("pend_k2", 64'(IOBUS_IN), 64'h1);
        check("intr_k2", 64'(INTR), 64'h0);
        bus_rd(A_PEND);
        check("intr_k3", 64'(INTR), 64'h1);
        bus_wr(A_PEND, 32'h1);
        check("w1c_pend", 64'(IOBUS_IN), 64'h0);
        bus_rd(A_PEND);
        check("w1c_intr", 64'(INTR), 64'h0);
        repeat (3) bus_rd(A_PEND);
        check("held_no_reset", 64'(IOBUS_IN), 64'h0);

        // Edge coinciding with W1C: set wins
        IRQ_SRC = 3'b000;
        repeat (3) bus_rd(A_PEND);
        IRQ_SRC = 3'b001;
        bus_rd(A_PEND);
        bus_rd(A_PEND);
        bus_wr(A_PEND, 32'h1);
        check("set_wins", 64'(IOBUS_IN[0]), 64'h1);
        IRQ_SRC = 3'b000;
        bus_wr(A_PEND, 32'hFFFF_FFFF);
        bus_wr(A_MASK, 32'h0);

`ifdef OTTER_MMIO_TIMER_EN
        // Timer wrap and compare interrupt
        bus_wr(A_TCMP, 32'h1);
        bus_wr(A_MASK, 32'h1 << N_IRQ);
        bus_wr(A_TCNT, 32'hFFFF_FFFE);
        bus_rd(A_TCNT);
        check("tcnt_ff", 64'(IOBUS_IN), 64'hFFFF_FFFF);
        bus_rd(A_TCNT);
        check("tcnt_wrap", 64'(IOBUS_IN), 64'h0);
        bus_rd(A_PEND);
        check("tmr_pend_early", 64'(IOBUS_IN), 64'h0);
        bus_rd(A_PEND);
        check("tmr_pend", 64'(IOBUS_IN), 64'(32'h1 << N_IRQ));
        check("tmr_intr_early", 64'(INTR), 64'h0);
        bus_rd(A_PEND);
        check("tmr_intr", 64'(INTR), 64'h1);
        bus_wr(A_TCMP, 32'hFFFF_FFFF);
        bus_wr(A_PEND, 32'hFFFF_FFFF);
        bus_wr(A_MASK, 32'h0);
`else
        bus_rd(A_TCNT);
        check("tcnt_unmapped", 64'(IOBUS_IN), 64'h0);
`endif

        // IRQ held high through reset: one set three edges after release
        IOBUS_ADDR = A_PEND;
        RST = 1'b1;
        IRQ_SRC = 3'b010;
        repeat (2) step();
        RST = 1'b0;
        bus_rd(A_PEND);
        bus_rd(A_PEND);
        check("rst_irq_r2", 64'(IOBUS_IN), 64'h0);
        bus_rd(A_PEND);
        check("rst_irq_r3", 64'(IOBUS_IN), 64'h2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            RST        = ($urandom_range(0, 199) == 0);
            IOBUS_ADDR = pick_addr($urandom_range(0, 12));
            IOBUS_WR   = ($urandom_range(0, 3) == 0);
            IOBUS_OUT  = $urandom;
            if ($urandom_range(0, 7) == 0) IN_PORTS = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) IRQ_SRC = 3'($urandom);
            step();
        end
        IOBUS_WR = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
